// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 encodings, response codes, FSM states
// and the access-size decode used by the request front end.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS   = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] size_lg;   // log2 of access size in bytes
    } size_dec_t;

    function automatic size_dec_t decode_size(input logic [2:0] f3, input logic store,
                                              input logic rv64);
        size_dec_t d;
        d.size_lg = f3[1:0];
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: d.legal = 1'b1;
            F3_D, F3_WU:                    d.legal = rv64;
            default:                        d.legal = 1'b0;
        endcase
        // Unsigned variants only make sense for loads.
        if (store && f3[2]) d.legal = 1'b0;
        return d;
    endfunction

    function automatic logic [2:0] align_mask(input logic [1:0] size_lg);
        case (size_lg)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for one access: byte enables and shifted store data towards memory,
// extracted and sign/zero-extended load data back from memory. Purely combinational.
module lsu_align #(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [1:0]                size_lg,
    input  logic                      sign_ext,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN/8-1:0]         be,
    output logic [XLEN-1:0]           wdata_sh,
    output logic [XLEN-1:0]           rdata_ext
);
    localparam int NB = XLEN / 8;

    logic [NB-1:0]   be_mask;
    logic [XLEN-1:0] shifted;
    logic            msb;
    int              nbits;

    always_comb begin
        case (size_lg)
            2'd0:    be_mask = NB'(1);
            2'd1:    be_mask = NB'(3);
            2'd2:    be_mask = NB'(15);
            default: be_mask = NB'(255);
        endcase
    end

    assign be       = be_mask << off;
    assign wdata_sh = wdata << {off, 3'b000};
    assign shifted  = rdata >> {off, 3'b000};

    always_comb begin
        nbits = 8 << size_lg;
        case (size_lg)
            2'd0:    msb = shifted[7];
            2'd1:    msb = shifted[15];
            2'd2:    msb = shifted[31];
            default: msb = shifted[XLEN-1];
        endcase
        rdata_ext = '0;
        for (int i = 0; i < XLEN; i++) begin
            rdata_ext[i] = (i < nbits) ? shifted[i] : (sign_ext & msb);
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request at a time through a req/gnt/rvalid memory port,
// with alignment checks, lane steering and a bus timeout; responds with a one-cycle pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_fun3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic [1:0]        rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);
    localparam int   NB    = XLEN / 8;
    localparam int   OFF_W = $clog2(NB);
    localparam logic RV64  = (XLEN == 64);

    state_t            state, state_nxt;
    logic [15:0]       cnt;
    logic              lat_store;
    logic [2:0]        lat_f3;
    logic [ADDR_W-1:0] lat_addr;
    logic [XLEN-1:0]   lat_wdata;
    logic [4:0]        lat_rd;
    logic [XLEN-1:0]   dat_q;
    logic [1:0]        err_q;

    size_dec_t         dec;
    logic              req_bad;
    logic              done;
    logic              tmo;
    logic [NB-1:0]     be;
    logic [XLEN-1:0]   wdata_sh;
    logic [XLEN-1:0]   rdata_ext;

    assign dec     = decode_size(req_fun3, req_store, RV64);
    assign req_bad = !dec.legal || (|(req_addr[2:0] & align_mask(dec.size_lg)));
    assign done    = (state == REQ && mem_gnt && mem_rvalid) || (state == WAIT && mem_rvalid);
    // Counter holds the number of REQ/WAIT cycles already spent before this one.
    assign tmo     = (state == REQ || state == WAIT) && (cnt == 16'(TIMEOUT - 1));

    lsu_align #(.XLEN(XLEN)) u_align (
        .off      (lat_addr[OFF_W-1:0]),
        .size_lg  (lat_f3[1:0]),
        .sign_ext (~lat_f3[2]),
        .wdata    (lat_wdata),
        .rdata    (mem_rdata),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata_ext(rdata_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = req_bad ? RESP : REQ;
            REQ: begin
                // A completing response wins over a coincident timeout.
                if (mem_gnt && mem_rvalid) state_nxt = RESP;
                else if (tmo)              state_nxt = RESP;
                else if (mem_gnt)          state_nxt = WAIT;
            end
            WAIT: if (mem_rvalid || tmo) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_req   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            REQ:     mem_req   = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            lat_store <= 1'b0;
            lat_f3    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_rd    <= '0;
            dat_q     <= '0;
            err_q     <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_store <= req_store;
                        lat_f3    <= req_fun3;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_rd    <= req_rd;
                        cnt       <= '0;
                        err_q     <= req_bad ? ERR_ALIGN : ERR_OK;
                        dat_q     <= '0;
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (done) begin
                        err_q <= mem_err ? ERR_BUS : ERR_OK;
                        dat_q <= (mem_err || lat_store) ? '0 : rdata_ext;
                    end else if (tmo) begin
                        err_q <= ERR_TMO;
                        dat_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = mem_req & lat_store;
    assign mem_addr  = mem_req ? {lat_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_wdata = (mem_req && lat_store) ? wdata_sh : '0;
    assign mem_be    = mem_req ? be : '0;
    assign rsp_rdata = rsp_valid ? dat_q : '0;
    assign rsp_rd    = rsp_valid ? lat_rd : '0;
    assign rsp_err   = rsp_valid ? err_q : ERR_OK;

endmodule
